nlp_update_gen: RTL and testbench

- Producer side of the NLP update channel. It turns backend branch-resolution events into NLP update packets on the backend update port.
- Each event is filtered: events that would not change NLP state are dropped.
- Surviving events are buffered in a small queue, and back-to-back events to the same NLP index are coalesced.
- Emits at most one packet per cycle; the top level packs the packet fields into the backend NLPUpdate interface.

---
 rtl/nlp_update_gen_pkg.sv | 25 ++
 rtl/nlp_upd_fifo.sv | 61 ++++++
 rtl/nlp_update_gen.sv | 121 ++++++++++++
 tb/tb_nlp_update_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nlp_update_gen_pkg.sv
// Shared types and helpers for NLP update producers.
// Used by nlp_update_gen and by the IF3-side producer.
package nlp_update_gen_pkg;

    localparam int IDX_LO_DEF = 3;
    localparam int IDX_W_DEF  = 6;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        should_take;
        logic [1:0]  bim;
    } nlp_upd_t;

    function automatic logic [1:0] sat_step(
        input logic [1:0] b,
        input logic       t
    );
        if (t)
            return (b == 2'd3) ? 2'd3 : b + 2'd1;
        else
            return (b == 2'd0) ? 2'd0 : b - 2'd1;
    endfunction

endpackage

// File: rtl/nlp_upd_fifo.sv
// DEPTH-entry update FIFO with push, pop, tail rewrite and flush.
// Flush has priority over every other same-cycle operation.
module nlp_upd_fifo
    import nlp_update_gen_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_push,
    input  nlp_upd_t    i_push_data,
    input  logic        i_pop,
    input  logic        i_rewrite,
    input  nlp_upd_t    i_rewrite_data,
    output nlp_upd_t    o_head,
    output nlp_upd_t    o_tail,
    output logic [AW:0] o_count
);

    nlp_upd_t        r_mem [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [AW:0]     r_count;
    logic [AW-1:0]   w_tail_m1;

    assign w_tail_m1 = r_tail - AW'(1);
    assign o_head    = r_mem[r_head];
    assign o_tail    = r_mem[w_tail_m1];
    assign o_count   = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_pop)
                r_head <= r_head + AW'(1);
            if (i_push) begin
                r_mem[r_tail] <= i_push_data;
                r_tail        <= r_tail + AW'(1);
            end
            if (i_rewrite)
                r_mem[w_tail_m1] <= i_rewrite_data;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/nlp_update_gen.sv
// Filters, coalesces and queues branch resolutions into NLP update packets.
// Optional stats counters are built when NLP_UPD_STATS_EN is defined.
module nlp_update_gen
    import nlp_update_gen_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int IDX_LO = IDX_LO_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ev_valid,
    input  logic [31:0] ev_pc,
    input  logic [31:0] ev_target,
    input  logic        ev_taken,
    input  logic        ev_pred_valid,
    input  logic [31:0] ev_pred_target,
    input  logic [1:0]  ev_pred_bim,
    input  logic        upd_ready,
    output logic        upd_valid,
    output logic [31:0] upd_pc,
    output logic [31:0] upd_target,
    output logic        upd_should_take,
    output logic [1:0]  upd_bim,
`ifdef NLP_UPD_STATS_EN
    output logic [31:0] stat_filtered,
    output logic [31:0] stat_coalesced,
    output logic [31:0] stat_overflow,
`endif
    output logic [AW:0] q_count
);

    localparam int IDX_HI = IDX_LO + IDX_W - 1;

    nlp_upd_t    w_head;
    nlp_upd_t    w_tail;
    nlp_upd_t    w_push_data;
    nlp_upd_t    w_rw_data;
    logic [AW:0] w_count;
    logic        w_needed;
    logic        w_live;
    logic        w_pop;
    logic        w_idx_match;
    logic        w_tail_popping;
    logic        w_coal;
    logic        w_space;
    logic        w_push;
    logic        w_ovf;

    // An event only matters if it would move the NLP entry.
    assign w_needed = !ev_pred_valid
        || (ev_taken && (ev_target != ev_pred_target))
        || (sat_step(ev_pred_bim, ev_taken) != ev_pred_bim);

    assign w_live         = ev_valid && w_needed;
    assign w_pop          = upd_valid && upd_ready;
    assign w_idx_match    = ev_pc[IDX_HI:IDX_LO] == w_tail.pc[IDX_HI:IDX_LO];
    assign w_tail_popping = w_pop && (w_count == (AW+1)'(1));
    assign w_coal  = w_live && (w_count != '0)
        && w_idx_match && !w_tail_popping;
    assign w_space = (w_count != (AW+1)'(DEPTH)) || w_pop;
    assign w_push  = w_live && !w_coal && w_space;
    assign w_ovf   = w_live && !w_coal && !w_space;

    assign w_push_data = '{pc: ev_pc, target: ev_target,
                           should_take: ev_taken, bim: ev_pred_bim};

    // Merged entry carries the older step folded into its bim.
    assign w_rw_data = '{pc: ev_pc, target: ev_target,
                         should_take: ev_taken,
                         bim: sat_step(w_tail.bim, w_tail.should_take)};

    nlp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .i_flush        (flush),
        .i_push         (w_push),
        .i_push_data    (w_push_data),
        .i_pop          (w_pop),
        .i_rewrite      (w_coal),
        .i_rewrite_data (w_rw_data),
        .o_head         (w_head),
        .o_tail         (w_tail),
        .o_count        (w_count)
    );

    assign q_count         = w_count;
    assign upd_valid       = (w_count != '0);
    assign upd_pc          = w_head.pc;
    assign upd_target      = w_head.target;
    assign upd_should_take = w_head.should_take;
    assign upd_bim         = w_head.bim;

`ifdef NLP_UPD_STATS_EN
    logic [31:0] r_stat_filt;
    logic [31:0] r_stat_coal;
    logic [31:0] r_stat_ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_filt <= '0;
            r_stat_coal <= '0;
            r_stat_ovf  <= '0;
        end else begin
            if (ev_valid && !w_needed && (r_stat_filt != '1))
                r_stat_filt <= r_stat_filt + 32'd1;
            if (!flush && w_coal && (r_stat_coal != '1))
                r_stat_coal <= r_stat_coal + 32'd1;
            if (!flush && w_ovf && (r_stat_ovf != '1))
                r_stat_ovf <= r_stat_ovf + 32'd1;
        end
    end

    assign stat_filtered  = r_stat_filt;
    assign stat_coalesced = r_stat_coal;
    assign stat_overflow  = r_stat_ovf;
`endif

endmodule

// File: tb/tb_nlp_update_gen.sv
// Randomized and directed bench for nlp_update_gen.
// Reference model keeps the queue as an SV queue of packets.
module tb_nlp_update_gen;
    import nlp_update_gen_pkg::*;

    localparam int DEPTH  = 4;
    localparam int IDX_LO = 3;
    localparam int IDX_W  = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ev_valid;
    logic [31:0] ev_pc;
    logic [31:0] ev_target;
    logic        ev_taken;
    logic        ev_pred_valid;
    logic [31:0] ev_pred_target;
    logic [1:0]  ev_pred_bim;
    logic        upd_ready;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_should_take;
    logic [1:0]  upd_bim;
    logic [2:0]  q_count;
`ifdef NLP_UPD_STATS_EN
    logic [31:0] stat_filtered;
    logic [31:0] stat_coalesced;
    logic [31:0] stat_overflow;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    nlp_upd_t mq[$];
    int m_filt, m_coal, m_ovf;

    always #5 clk = ~clk;

    nlp_update_gen #(.DEPTH(DEPTH), .IDX_LO(IDX_LO), .IDX_W(IDX_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .ev_valid        (ev_valid),
        .ev_pc           (ev_pc),
        .ev_target       (ev_target),
        .ev_taken        (ev_taken),
        .ev_pred_valid   (ev_pred_valid),
        .ev_pred_target  (ev_pred_target),
        .ev_pred_bim     (ev_pred_bim),
        .upd_ready       (upd_ready),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_target      (upd_target),
        .upd_should_take (upd_should_take),
        .upd_bim         (upd_bim),
`ifdef NLP_UPD_STATS_EN
        .stat_filtered   (stat_filtered),
        .stat_coalesced  (stat_coalesced),
        .stat_overflow   (stat_overflow),
`endif
        .q_count         (q_count)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int step2(input int b, input bit t);
        if (t) return (b >= 3) ? 3 : b + 1;
        return (b <= 0) ? 0 : b - 1;
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> IDX_LO) % (32'd1 << IDX_W));
    endfunction

    task automatic set_ev(input logic [31:0] pc, input logic [31:0] tgt,
                          input bit tk, input bit pv,
                          input logic [31:0] ptgt, input logic [1:0] pb);
        ev_valid = 1'b1;
        ev_pc = pc;
        ev_target = tgt;
        ev_taken = tk;
        ev_pred_valid = pv;
        ev_pred_target = ptgt;
        ev_pred_bim = pb;
    endtask

    task automatic model_edge(input bit pop);
        int n;
        bit need;
        bit do_push;
        nlp_upd_t e;
        n = mq.size();
        do_push = 1'b0;
        need = !ev_pred_valid
            || (ev_taken && ev_target != ev_pred_target)
            || (step2(int'(ev_pred_bim), ev_taken) != int'(ev_pred_bim));
        if (ev_valid && !need) m_filt++;
        if (flush) begin
            mq.delete();
            return;
        end
        if (ev_valid && need) begin
            if (n > 0 && idx_of(ev_pc) == idx_of(mq[n-1].pc)
                && !(pop && n == 1)) begin
                e = mq[n-1];
                e.bim = 2'(step2(int'(e.bim), e.should_take));
                e.should_take = ev_taken;
                e.target = ev_target;
                e.pc = ev_pc;
                mq[n-1] = e;
                m_coal++;
            end else if (n < DEPTH || pop) begin
                do_push = 1'b1;
            end else begin
                m_ovf++;
            end
        end
        if (pop) void'(mq.pop_front());
        if (do_push)
            mq.push_back('{pc: ev_pc, target: ev_target,
                           should_take: ev_taken, bim: ev_pred_bim});
    endtask

    task automatic cycle();
        bit pop;
        chk("upd_valid", 64'(upd_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("upd_pc", 64'(upd_pc), 64'(mq[0].pc));
            chk("upd_target", 64'(upd_target), 64'(mq[0].target));
            chk("upd_take", 64'(upd_should_take),
                64'(mq[0].should_take));
            chk("upd_bim", 64'(upd_bim), 64'(mq[0].bim));
        end
        pop = (mq.size() != 0) && upd_ready;
        @(posedge clk);
        model_edge(pop);
        #1;
        chk("q_count", 64'(q_count), 64'(mq.size()));
`ifdef NLP_UPD_STATS_EN
        chk("stat_filt", 64'(stat_filtered), 64'(m_filt));
        chk("stat_coal", 64'(stat_coalesced), 64'(m_coal));
        chk("stat_ovf", 64'(stat_overflow), 64'(m_ovf));
`endif
    endtask

    task automatic idle_ev();
        ev_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        mq.delete();
        m_filt = 0;
        m_coal = 0;
        m_ovf = 0;
        chk("rst_valid", 64'(upd_valid), 64'd0);
        chk("rst_count", 64'(q_count), 64'd0);
        chk("rst_pc", 64'(upd_pc), 64'd0);
        chk("rst_bim", 64'(upd_bim), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain();
        idle_ev();
        upd_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cycle();
    endtask

    initial begin
        int f0, o0;
        rst = 1'b0;
        flush = 1'b0;
        upd_ready = 1'b0;
        set_ev(0, 0, 0, 0, 0, 0);
        ev_valid = 1'b0;
        #1;
        apply_reset();
        for (int i = 0; i < 3; i++) cycle();

        // single packet
        upd_ready = 1'b1;
        set_ev(32'h100, 32'h200, 1, 0, 32'h0, 2'd1);
        cycle();
        idle_ev();
        chk("t1_valid", 64'(upd_valid), 64'd1);
        chk("t1_pc", 64'(upd_pc), 64'h100);
        chk("t1_tgt", 64'(upd_target), 64'h200);
        chk("t1_take", 64'(upd_should_take), 64'd1);
        chk("t1_bim", 64'(upd_bim), 64'd1);
        cycle();
        chk("t1_popped", 64'(q_count), 64'd0);

        // filter drop
        f0 = m_filt;
        set_ev(32'h140, 32'h300, 1, 1, 32'h300, 2'd3);
        cycle();
        idle_ev();
        chk("filt_count", 64'(q_count), 64'd0);
        chk("filt_model", 64'(m_filt - f0), 64'd1);

        // coalesce
        upd_ready = 1'b0;
        set_ev(32'h108, 32'h400, 1, 0, 32'h0, 2'd1);
        cycle();
        set_ev(32'h108, 32'h400, 1, 0, 32'h0, 2'd1);
        cycle();
        idle_ev();
        chk("coal_count", 64'(q_count), 64'd1);
        chk("coal_bim", 64'(upd_bim), 64'd2);
        chk("coal_end", 64'(step2(int'(upd_bim), upd_should_take)),
            64'd3);
        drain();

        // overflow
        o0 = m_ovf;
        upd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_ev(32'h200 + 32'(i * 8), 32'h500, 1, 0, 0, 2'd0);
            cycle();
        end
        idle_ev();
        chk("ovf_count", 64'(q_count), 64'd4);
        chk("ovf_model", 64'(m_ovf - o0), 64'd1);
        upd_ready = 1'b1;
        set_ev(32'h228, 32'h600, 0, 0, 0, 2'd2);
        cycle();
        idle_ev();
        chk("full_pushpop", 64'(q_count), 64'd4);
        drain();

        // flush with same-cycle event
        upd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_ev(32'h300 + 32'(i * 8), 32'h700, 1, 0, 0, 2'd1);
            cycle();
        end
        set_ev(32'h320, 32'h700, 1, 0, 0, 2'd1);
        flush = 1'b1;
        cycle();
        idle_ev();
        chk("flush_count", 64'(q_count), 64'd0);
        chk("flush_valid", 64'(upd_valid), 64'd0);

        // reset mid-stream with two entries queued
        for (int i = 0; i < 2; i++) begin
            set_ev(32'h400 + 32'(i * 8), 32'h800, 1, 0, 0, 2'd1);
            cycle();
        end
        idle_ev();
        chk("pre_rst_count", 64'(q_count), 64'd2);
        apply_reset();
        for (int i = 0; i < 2; i++) cycle();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            ev_valid = ($urandom_range(0, 3) != 0);
            ev_pc = (32'($urandom_range(0, 3)) << 3)
                  | (32'($urandom_range(0, 1)) << 12);
            ev_target = 32'($urandom_range(0, 3)) << 4;
            ev_pred_target = 32'($urandom_range(0, 3)) << 4;
            ev_taken = 1'($urandom_range(0, 1));
            ev_pred_valid = ($urandom_range(0, 3) != 0);
            ev_pred_bim = 2'($urandom_range(0, 3));
            upd_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 40) == 0);
            cycle();
        end
        idle_ev();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
